// File: rtl/wb_arb_stage_pkg.sv
// wb_pkg: shared writeback entry type, load encodings and result formatting.
package wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 5;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_RSVD} wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [WB_DW-1:0] alu_result;
        logic [WB_DW-1:0] mem_data;
        wb_sel_e          wb_sel;
        logic [2:0]       funct3;
        logic [1:0]       byte_off;
        logic [WB_AW-1:0] rd;
        logic             reg_write;
    } wb_entry_t;

    function automatic logic [WB_DW-1:0] wb_format(input wb_entry_t e);
        logic [7:0]       b;
        logic [15:0]      h;
        logic [WB_DW-1:0] r;
        b = e.mem_data[{e.byte_off, 3'b000} +: 8];
        h = e.mem_data[{e.byte_off[1], 4'b0000} +: 16];
        case (e.funct3)
            F3_LB:   r = {{(WB_DW-8){b[7]}}, b};
            F3_LBU:  r = {{(WB_DW-8){1'b0}}, b};
            F3_LH:   r = {{(WB_DW-16){h[15]}}, h};
            F3_LHU:  r = {{(WB_DW-16){1'b0}}, h};
            F3_LW:   r = e.mem_data;
            default: r = '0;
        endcase
        return (e.wb_sel == WB_MEM) ? r : e.alu_result;
    endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// wb_chan_fifo: per-channel result buffer with count-based full/empty.
module wb_chan_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign dout    = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_pop)
                rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/wb_arb_stage.sv
// wb_arb_stage: buffers per-producer results and retires one per cycle round-robin
// into the registered register-file write port.
module wb_arb_stage
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int REG_ADDR_W = 5,
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              in_valid,
    output logic [NUM_CH-1:0]              in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_alu_result,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_mem_data,
    input  logic [NUM_CH*2-1:0]            in_wb_sel,
    input  logic [NUM_CH*3-1:0]            in_funct3,
    input  logic [NUM_CH*2-1:0]            in_byte_off,
    input  logic [NUM_CH*REG_ADDR_W-1:0]   in_rd,
    input  logic [NUM_CH-1:0]              in_reg_write,
    output logic                           rf_we,
    output logic [REG_ADDR_W-1:0]          rf_waddr,
    output logic [DATA_WIDTH-1:0]          rf_wdata,
    output logic                           wb_retire,
    output logic [CW-1:0]                  wb_retire_ch
);
    wb_entry_t           ent  [NUM_CH];
    wb_entry_t           head [NUM_CH];
    wb_entry_t           sel;
    logic [NUM_CH-1:0]   full, empty, pop;
    logic [CW-1:0]       p, g;
    logic                gnt;

    assign in_ready = ~full;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ent[c] = '{
            alu_result: in_alu_result[c*DATA_WIDTH +: DATA_WIDTH],
            mem_data:   in_mem_data[c*DATA_WIDTH +: DATA_WIDTH],
            wb_sel:     wb_sel_e'(in_wb_sel[c*2 +: 2]),
            funct3:     in_funct3[c*3 +: 3],
            byte_off:   in_byte_off[c*2 +: 2],
            rd:         in_rd[c*REG_ADDR_W +: REG_ADDR_W],
            reg_write:  in_reg_write[c]
        };
        wb_chan_fifo #(.W($bits(wb_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (in_valid[c] && !full[c]),
            .pop   (pop[c]),
            .din   (ent[c]),
            .dout  (head[c]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    // Scan offsets high to low so the closest eligible channel at or after p wins.
    always_comb begin
        gnt = 1'b0;
        g   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!empty[(int'(p) + i) % NUM_CH]) begin
                gnt = 1'b1;
                g   = CW'((int'(p) + i) % NUM_CH);
            end
        end
    end

    assign pop = gnt ? (NUM_CH'(1) << g) : '0;
    assign sel = head[g];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p            <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            wb_retire    <= 1'b0;
            wb_retire_ch <= '0;
        end else begin
            rf_we     <= 1'b0;
            wb_retire <= gnt;
            if (gnt) begin
                p            <= (g == CW'(NUM_CH - 1)) ? '0 : g + 1'b1;
                rf_waddr     <= sel.rd;
                rf_wdata     <= wb_format(sel);
                rf_we        <= sel.reg_write && sel.rd != '0;
                wb_retire_ch <= g;
            end
        end
    end

endmodule

// File: tb/tb_wb_arb_stage.sv
// tb_wb_arb_stage: directed vectors plus multi-cycle sequences for wb_arb_stage.
module tb_wb_arb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid, in_ready, in_reg_write;
    logic [95:0] in_alu_result, in_mem_data;
    logic [5:0]  in_wb_sel, in_byte_off;
    logic [8:0]  in_funct3;
    logic [14:0] in_rd;
    logic        rf_we, wb_retire;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  wb_retire_ch;

    int nvec = 0;
    int nfail = 0;

    wb_arb_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_wb_sel(in_wb_sel),
        .in_funct3(in_funct3), .in_byte_off(in_byte_off), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_retire(wb_retire), .wb_retire_ch(wb_retire_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        we;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int ch, input logic [1:0] sel, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] alu, input logic [31:0] mem,
                          input logic [4:0] rd, input logic rw);
        in_wb_sel[ch*2 +: 2]      = sel;
        in_funct3[ch*3 +: 3]      = f3;
        in_byte_off[ch*2 +: 2]    = off;
        in_alu_result[ch*32 +: 32] = alu;
        in_mem_data[ch*32 +: 32]  = mem;
        in_rd[ch*5 +: 5]          = rd;
        in_reg_write[ch]          = rw;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] q [$];
        logic [4:0] expq [$];
        int nret, nwe, nr;
        logic acc;

        tbl[0]  = '{2'd1, 3'b000, 2'd0, 32'h1234_5678, 5'd10, 1'b1, 1'b1, 32'hFFFF_FF81};
        tbl[1]  = '{2'd1, 3'b100, 2'd3, 32'h1234_5678, 5'd11, 1'b1, 1'b1, 32'h0000_0080};
        tbl[2]  = '{2'd1, 3'b001, 2'd2, 32'h1234_5678, 5'd12, 1'b1, 1'b1, 32'hFFFF_80FF};
        tbl[3]  = '{2'd1, 3'b101, 2'd1, 32'h1234_5678, 5'd13, 1'b1, 1'b1, 32'h0000_7F81};
        tbl[4]  = '{2'd1, 3'b010, 2'd3, 32'h1234_5678, 5'd14, 1'b1, 1'b1, 32'h80FF_7F81};
        tbl[5]  = '{2'd1, 3'b011, 2'd0, 32'h1234_5678, 5'd15, 1'b1, 1'b1, 32'h0000_0000};
        tbl[6]  = '{2'd1, 3'b000, 2'd1, 32'h1234_5678, 5'd16, 1'b1, 1'b1, 32'h0000_007F};
        tbl[7]  = '{2'd2, 3'b000, 2'd0, 32'h0000_0104, 5'd17, 1'b1, 1'b1, 32'h0000_0104};
        tbl[8]  = '{2'd3, 3'b000, 2'd0, 32'hDEAD_BEEF, 5'd18, 1'b1, 1'b1, 32'hDEAD_BEEF};
        tbl[9]  = '{2'd0, 3'b010, 2'd0, 32'h0000_0055, 5'd0,  1'b1, 1'b0, 32'h0000_0055};
        tbl[10] = '{2'd0, 3'b010, 2'd0, 32'h0000_0066, 5'd7,  1'b0, 1'b0, 32'h0000_0066};

        in_alu_result = '0; in_mem_data = '0; in_wb_sel = '0; in_funct3 = '0;
        in_byte_off = '0; in_rd = '0; in_reg_write = '0; in_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rf_we", rf_we, 0);
        chk("reset rf_waddr", rf_waddr, 0);
        chk("reset rf_wdata", rf_wdata, 0);
        chk("reset wb_retire", wb_retire, 0);
        chk("reset retire_ch", wb_retire_ch, 0);
        chk("reset in_ready", in_ready, 3'b111);
        rst_n = 1'b1;

        // single ALU entry on ch0: visible two edges after acceptance
        set_ch(0, 2'd0, 3'b010, 2'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        in_valid[0] = 1'b1;
        @(posedge clk); #1 in_valid[0] = 1'b0;
        chk("alu not early", rf_we, 0);
        @(posedge clk); #1;
        chk("alu rf_we", rf_we, 1);
        chk("alu waddr", rf_waddr, 5);
        chk("alu wdata", rf_wdata, 32'h0000_1234);
        chk("alu retire", wb_retire, 1);
        chk("alu retire_ch", wb_retire_ch, 0);
        @(posedge clk); #1;
        chk("alu we drop", rf_we, 0);
        chk("alu retire drop", wb_retire, 0);
        chk("alu wdata hold", rf_wdata, 32'h0000_1234);

        // formatting and x0/no-write vectors on ch1
        for (int i = 0; i < 11; i++) begin
            set_ch(1, tbl[i].sel, tbl[i].f3, tbl[i].off, tbl[i].alu, 32'h80FF_7F81, tbl[i].rd, tbl[i].rw);
            in_valid[1] = 1'b1;
            @(posedge clk); #1 in_valid[1] = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("vec%0d rf_we", i), rf_we, tbl[i].we);
            chk($sformatf("vec%0d waddr", i), rf_waddr, tbl[i].rd);
            chk($sformatf("vec%0d wdata", i), rf_wdata, tbl[i].wd);
            chk($sformatf("vec%0d retire", i), wb_retire, 1);
            chk($sformatf("vec%0d retire_ch", i), wb_retire_ch, 1);
        end

        // mid-operation reset discards buffered entries
        for (int c = 0; c < 3; c++) set_ch(c, 2'd0, 3'b010, 2'd0, 32'hA0 + c, 32'h0, 5'(c + 1), 1'b1);
        in_valid = 3'b111;
        repeat (2) @(posedge clk);
        #1 in_valid = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst rf_we", rf_we, 0);
        chk("mrst waddr", rf_waddr, 0);
        chk("mrst wdata", rf_wdata, 0);
        chk("mrst retire", wb_retire, 0);
        chk("mrst retire_ch", wb_retire_ch, 0);
        chk("mrst in_ready", in_ready, 3'b111);
        rst_n = 1'b1;
        nwe = 0; nr = 0;
        repeat (6) begin
            @(posedge clk); #1;
            nwe += int'(rf_we);
            nr  += int'(wb_retire);
        end
        chk("mrst no writes", nwe, 0);
        chk("mrst no retires", nr, 0);

        // round-robin with all channels saturated
        in_valid = 3'b111;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rr%0d waddr", k), rf_waddr, 5'(k % 3 + 1));
            chk($sformatf("rr%0d rf_we", k), rf_we, 1);
        end
        in_valid = '0;
        repeat (10) @(posedge clk);
        #1 do_reset();

        // backpressure: ch2 producer holds each entry until accepted
        q = '{5'd20, 5'd21, 5'd22, 5'd23};
        expq = q;
        nret = 0;
        set_ch(0, 2'd0, 3'b010, 2'd0, 32'h1, 32'h0, 5'd1, 1'b1);
        set_ch(1, 2'd0, 3'b010, 2'd0, 32'h2, 32'h0, 5'd2, 1'b1);
        for (int cyc = 0; cyc < 24; cyc++) begin
            in_valid[0] = cyc < 12;
            in_valid[1] = cyc < 12;
            in_valid[2] = q.size() > 0;
            if (q.size() > 0) set_ch(2, 2'd0, 3'b010, 2'd0, 32'(q[0]), 32'h0, q[0], 1'b1);
            @(negedge clk);
            acc = in_valid[2] && in_ready[2];
            @(posedge clk); #1;
            if (acc) void'(q.pop_front());
            if (wb_retire && wb_retire_ch == 2'd2) begin
                chk($sformatf("bp ch2 order %0d", nret), rf_waddr, (nret < 4) ? expq[nret] : 5'd0);
                chk($sformatf("bp ch2 data %0d", nret), rf_wdata, (nret < 4) ? 32'(expq[nret]) : 32'd0);
                nret++;
            end
            if (cyc == 1) begin
                chk("bp ready2 low", in_ready[2], 0);
                chk("bp accepted 2", 4 - q.size(), 2);
            end
        end
        in_valid = '0;
        chk("bp all pushed", q.size(), 0);
        chk("bp ch2 retired", nret, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
